// File: rtl/axis_mux_serializer_if.sv
// Bundle of the per-channel AXIS inputs and the credit-based flit link of axis_mux_serializer.
// master: upstream sources and downstream sink; slave: the serializer itself.
interface axis_mux_serializer_if #(
    parameter int unsigned NUM_CHANNELS         = 4,
    parameter int unsigned TID_WIDTH            = 2,
    parameter int unsigned TDEST_WIDTH          = 4,
    parameter int unsigned TDATA_WIDTH          = 512,
    parameter int unsigned SERIALIZATION_FACTOR = 4
);
    localparam int unsigned FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR;
    localparam int unsigned DEST_WIDTH = TID_WIDTH + TDEST_WIDTH;

    logic [NUM_CHANNELS-1:0]                  axis_in_tvalid;
    logic [NUM_CHANNELS-1:0]                  axis_in_tready;
    logic [NUM_CHANNELS-1:0][TDATA_WIDTH-1:0] axis_in_tdata;
    logic [NUM_CHANNELS-1:0]                  axis_in_tlast;
    logic [NUM_CHANNELS-1:0][TID_WIDTH-1:0]   axis_in_tid;
    logic [NUM_CHANNELS-1:0][TDEST_WIDTH-1:0] axis_in_tdest;

    logic [FLIT_WIDTH-1:0] data_out;
    logic [DEST_WIDTH-1:0] dest_out;
    logic                  is_tail_out;
    logic                  send_out;
    logic                  credit_in;

    modport master (
        output axis_in_tvalid, axis_in_tdata, axis_in_tlast, axis_in_tid, axis_in_tdest,
        output credit_in,
        input  axis_in_tready, data_out, dest_out, is_tail_out, send_out
    );

    modport slave (
        input  axis_in_tvalid, axis_in_tdata, axis_in_tlast, axis_in_tid, axis_in_tdest,
        input  credit_in,
        output axis_in_tready, data_out, dest_out, is_tail_out, send_out
    );
endinterface

// File: rtl/axis_mux_serializer.sv
// Round-robin AXIS packet mux that serializes each beat into flits on a credit-based link.
// Optional per-channel packet counters: define AXIS_MUX_SERIALIZER_STATS_EN.
module axis_mux_serializer #(
    parameter int unsigned NUM_CHANNELS         = 4,
    parameter int unsigned TID_WIDTH            = 2,
    parameter int unsigned TDEST_WIDTH          = 4,
    parameter int unsigned TDATA_WIDTH          = 512,
    parameter int unsigned SERIALIZATION_FACTOR = 4,
    parameter int unsigned FLIT_BUFFER_DEPTH    = 4
) (
    input  logic clk_noc,
    input  logic rst_noc_sync,
`ifdef AXIS_MUX_SERIALIZER_STATS_EN
    output logic [NUM_CHANNELS-1:0][31:0] pkt_count,
`endif
    axis_mux_serializer_if.slave bus
);
    localparam int unsigned FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR;
    localparam int unsigned DEST_WIDTH = TID_WIDTH + TDEST_WIDTH;
    localparam int unsigned CreditW    = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam int unsigned ChW        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned IdxW       = (SERIALIZATION_FACTOR > 1) ?
                                         $clog2(SERIALIZATION_FACTOR) : 1;

    localparam logic [CreditW-1:0] CreditMax = CreditW'(FLIT_BUFFER_DEPTH);
    localparam logic [IdxW-1:0]    LastIdx   = IdxW'(SERIALIZATION_FACTOR - 1);
    localparam logic [ChW-1:0]     LastCh    = ChW'(NUM_CHANNELS - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;

    state_e                 state_q;
    logic [CreditW-1:0]     credits_q;
    logic [ChW-1:0]         last_grant_q;
    logic [ChW-1:0]         lock_q;
    logic [IdxW-1:0]        idx_q;
    logic                   last_q;
    logic [TDATA_WIDTH-1:0] shreg_q;
    logic [DEST_WIDTH-1:0]  dest_q;
    logic [FLIT_WIDTH-1:0]  data_hold_q;
    logic [DEST_WIDTH-1:0]  dest_hold_q;
    logic                   tail_hold_q;

    logic                    grant_valid;
    logic [ChW-1:0]          grant_ch;
    logic [ChW-1:0]          cand;
    logic [ChW-1:0]          sel_ch;
    logic [NUM_CHANNELS-1:0] ready;
    logic                    xfer;
    logic                    send;
    logic                    flit_last;
    logic                    tail_sent;

    // Round-robin search starting just above the previous winner.
    always_comb begin
        grant_valid = 1'b0;
        grant_ch    = last_grant_q;
        cand        = last_grant_q;
        for (int unsigned off = 1; off <= NUM_CHANNELS; off++) begin
            cand = ChW'((32'(last_grant_q) + off) % NUM_CHANNELS);
            if (!grant_valid && bus.axis_in_tvalid[cand]) begin
                grant_valid = 1'b1;
                grant_ch    = cand;
            end
        end
    end

    assign send      = (state_q == StSend) && (credits_q != '0) && !rst_noc_sync;
    assign flit_last = (idx_q == LastIdx);
    assign tail_sent = send && flit_last && last_q;

    always_comb begin
        ready  = '0;
        sel_ch = lock_q;
        case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    sel_ch        = grant_ch;
                    ready[grant_ch] = 1'b1;
                end
            end
            StLoad: ready[lock_q] = bus.axis_in_tvalid[lock_q];
            // Ask for the next beat while the last flit goes out, keeping the link busy.
            StSend: ready[lock_q] = send && flit_last && !last_q;
            default: ready = '0;
        endcase
        if (rst_noc_sync) begin
            ready = '0;
        end
    end

    assign xfer               = |(ready & bus.axis_in_tvalid);
    assign bus.axis_in_tready = ready;
    assign bus.send_out       = send;
    assign bus.data_out       = send ? shreg_q[FLIT_WIDTH-1:0] : data_hold_q;
    assign bus.dest_out       = send ? dest_q : dest_hold_q;
    assign bus.is_tail_out    = send ? (flit_last && last_q) : tail_hold_q;

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            state_q      <= StIdle;
            credits_q    <= CreditMax;
            last_grant_q <= LastCh;
            lock_q       <= '0;
            idx_q        <= '0;
            last_q       <= 1'b0;
            shreg_q      <= '0;
            dest_q       <= '0;
            data_hold_q  <= '0;
            dest_hold_q  <= '0;
            tail_hold_q  <= 1'b0;
        end else begin
            if (send) begin
                shreg_q     <= shreg_q >> FLIT_WIDTH;
                idx_q       <= idx_q + 1'b1;
                data_hold_q <= shreg_q[FLIT_WIDTH-1:0];
                dest_hold_q <= dest_q;
                tail_hold_q <= flit_last && last_q;
            end
            if (xfer) begin
                shreg_q <= bus.axis_in_tdata[sel_ch];
                last_q  <= bus.axis_in_tlast[sel_ch];
                idx_q   <= '0;
                lock_q  <= sel_ch;
                if (state_q == StIdle) begin
                    dest_q <= {bus.axis_in_tid[sel_ch], bus.axis_in_tdest[sel_ch]};
                end
            end

            case ({send, bus.credit_in})
                2'b10:   credits_q <= credits_q - 1'b1;
                2'b01:   if (credits_q != CreditMax) credits_q <= credits_q + 1'b1;
                default: credits_q <= credits_q;
            endcase

            case (state_q)
                StIdle: if (xfer) state_q <= StSend;
                StLoad: if (xfer) state_q <= StSend;
                StSend: begin
                    if (send && flit_last) begin
                        if (last_q) begin
                            state_q      <= StIdle;
                            last_grant_q <= lock_q;
                        end else if (!xfer) begin
                            state_q <= StLoad;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef AXIS_MUX_SERIALIZER_STATS_EN
    logic [NUM_CHANNELS-1:0][31:0] pkt_count_q;

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            pkt_count_q <= '0;
        end else if (tail_sent) begin
            pkt_count_q[lock_q] <= pkt_count_q[lock_q] + 32'd1;
        end
    end

    assign pkt_count = pkt_count_q;
`else
    logic unused_tail;
    assign unused_tail = tail_sent;
`endif
endmodule

// File: tb/tb_axis_mux_serializer.sv
// Directed bench for axis_mux_serializer: 4 channels, 32-bit beats split into four 8-bit flits.
module tb_axis_mux_serializer;
    localparam int unsigned NC  = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned SF  = 4;
    localparam int unsigned FBD = 4;

    logic clk_noc = 1'b0;
    logic rst_noc_sync = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk_noc = ~clk_noc;

    axis_mux_serializer_if #(
        .NUM_CHANNELS(NC), .TID_WIDTH(2), .TDEST_WIDTH(4),
        .TDATA_WIDTH(DW), .SERIALIZATION_FACTOR(SF)
    ) bus ();

`ifdef AXIS_MUX_SERIALIZER_STATS_EN
    logic [NC-1:0][31:0] pkt_count;
`endif

    axis_mux_serializer #(
        .NUM_CHANNELS(NC), .TID_WIDTH(2), .TDEST_WIDTH(4), .TDATA_WIDTH(DW),
        .SERIALIZATION_FACTOR(SF), .FLIT_BUFFER_DEPTH(FBD)
    ) dut (
        .clk_noc      (clk_noc),
        .rst_noc_sync (rst_noc_sync),
`ifdef AXIS_MUX_SERIALIZER_STATS_EN
        .pkt_count    (pkt_count),
`endif
        .bus          (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nc();
        @(negedge clk_noc);
    endtask

    task automatic clear_inputs();
        bus.axis_in_tvalid = '0;
        bus.axis_in_tdata  = '0;
        bus.axis_in_tlast  = '0;
        bus.axis_in_tid    = '0;
        bus.axis_in_tdest  = '0;
        bus.credit_in      = 1'b0;
    endtask

    task automatic set_ch(input int ch, input logic [31:0] d, input logic l,
                          input logic [1:0] id, input logic [3:0] de, input logic v);
        bus.axis_in_tdata[ch]  = d;
        bus.axis_in_tlast[ch]  = l;
        bus.axis_in_tid[ch]    = id;
        bus.axis_in_tdest[ch]  = de;
        bus.axis_in_tvalid[ch] = v;
    endtask

    task automatic do_reset();
        nc();
        rst_noc_sync = 1'b1;
        clear_inputs();
        nc();
        nc();
        rst_noc_sync = 1'b0;
    endtask

    logic [7:0] exp_a [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    initial begin
        clear_inputs();
        // Reset state, with tvalid asserted to show no beat is accepted under reset.
        nc();
        nc();
        bus.axis_in_tvalid = 4'hF;
        #1;
        check("rst_tready", 64'(bus.axis_in_tready), 64'h0);
        check("rst_send", 64'(bus.send_out), 64'h0);
        check("rst_data", 64'(bus.data_out), 64'h0);
        check("rst_dest", 64'(bus.dest_out), 64'h0);
        check("rst_tail", 64'(bus.is_tail_out), 64'h0);
        bus.axis_in_tvalid = '0;
        nc();
        rst_noc_sync = 1'b0;

        // Single-beat packet on channel 2, tid=1 tdest=5, credits returned every cycle.
        bus.credit_in = 1'b1;
        set_ch(2, 32'hDDCCBBAA, 1'b1, 2'd1, 4'd5, 1'b1);
        #1;
        check("a_grant", 64'(bus.axis_in_tready), 64'h4);
        check("a_nosend", 64'(bus.send_out), 64'h0);
        for (int k = 0; k < 4; k++) begin
            nc();
            if (k == 0) bus.axis_in_tvalid = '0;
            #1;
            check("a_send", 64'(bus.send_out), 64'h1);
            check("a_data", 64'(bus.data_out), 64'(exp_a[k]));
            check("a_dest", 64'(bus.dest_out), 64'h15);
            check("a_tail", 64'(bus.is_tail_out), 64'(k == 3));
            check("a_tready", 64'(bus.axis_in_tready), 64'h0);
        end
        nc();
        #1;
        check("a_idle", 64'(bus.send_out), 64'h0);
        check("a_hold_data", 64'(bus.data_out), 64'hDD);
        check("a_hold_dest", 64'(bus.dest_out), 64'h15);

        // All four channels valid: grants 0,1,2,3,0 with no interleaving.
        do_reset();
        bus.credit_in = 1'b1;
        for (int c = 0; c < 4; c++) begin
            set_ch(c, {8'(c * 16 + 3), 8'(c * 16 + 2), 8'(c * 16 + 1), 8'(c * 16)},
                   1'b1, 2'(c), 4'(c + 8), 1'b1);
        end
        for (int p = 0; p < 5; p++) begin
            if (p != 0) nc();
            #1;
            check("b_grant", 64'(bus.axis_in_tready), 64'h1 << (p % 4));
            for (int k = 0; k < 4; k++) begin
                nc();
                if (p == 4 && k == 3) bus.axis_in_tvalid = '0;
                #1;
                check("b_send", 64'(bus.send_out), 64'h1);
                check("b_data", 64'(bus.data_out), 64'((p % 4) * 16 + k));
                check("b_dest", 64'(bus.dest_out), 64'(((p % 4) << 4) | ((p % 4) + 8)));
                check("b_tail", 64'(bus.is_tail_out), 64'(k == 3));
                check("b_tready", 64'(bus.axis_in_tready), 64'h0);
            end
        end

        // 3-beat packet on channel 1 with no credits returned: 4 flits then stall.
        do_reset();
        bus.credit_in = 1'b1;
        nc();
        nc();
        nc();
        bus.credit_in = 1'b0;
        set_ch(1, 32'hA3A2A1A0, 1'b0, 2'd2, 4'd3, 1'b1);
        #1;
        check("c_grant", 64'(bus.axis_in_tready), 64'h2);
        for (int k = 0; k < 4; k++) begin
            nc();
            if (k == 0) set_ch(1, 32'hB3B2B1B0, 1'b0, 2'd2, 4'd3, 1'b1);
            #1;
            check("c_send", 64'(bus.send_out), 64'h1);
            check("c_data", 64'(bus.data_out), 64'(8'hA0 + k));
            check("c_tready", 64'(bus.axis_in_tready), (k == 3) ? 64'h2 : 64'h0);
        end
        nc();
        set_ch(1, 32'hC3C2C1C0, 1'b1, 2'd2, 4'd3, 1'b1);
        #1;
        check("c_stall", 64'(bus.send_out), 64'h0);
        check("c_hold", 64'(bus.data_out), 64'hA3);
        check("c_stall_tready", 64'(bus.axis_in_tready), 64'h0);
        nc();
        #1;
        check("c_stall2", 64'(bus.send_out), 64'h0);
        nc();
        bus.credit_in = 1'b1;
        #1;
        check("c_stall3", 64'(bus.send_out), 64'h0);
        nc();
        #1;
        check("c_cr_send0", 64'(bus.send_out), 64'h1);
        check("c_cr_data0", 64'(bus.data_out), 64'hB0);
        nc();
        bus.credit_in = 1'b0;
        #1;
        check("c_cr_send1", 64'(bus.send_out), 64'h1);
        check("c_cr_data1", 64'(bus.data_out), 64'hB1);
        nc();
        #1;
        check("c_after0", 64'(bus.send_out), 64'h0);
        check("c_after_hold", 64'(bus.data_out), 64'hB1);
        nc();
        #1;
        check("c_after1", 64'(bus.send_out), 64'h0);

        // 3-beat packet, tvalid always high, unlimited credits: 12 flits back to back.
        do_reset();
        bus.credit_in = 1'b1;
        set_ch(0, 32'h43424140, 1'b0, 2'd0, 4'd2, 1'b1);
        #1;
        check("d_grant", 64'(bus.axis_in_tready), 64'h1);
        for (int i = 0; i < 12; i++) begin
            nc();
            if (i == 0) set_ch(0, 32'h47464544, 1'b0, 2'd0, 4'd2, 1'b1);
            if (i == 4) set_ch(0, 32'h4B4A4948, 1'b1, 2'd0, 4'd2, 1'b1);
            if (i == 8) bus.axis_in_tvalid = '0;
            #1;
            check("d_send", 64'(bus.send_out), 64'h1);
            check("d_data", 64'(bus.data_out), 64'(8'h40 + i));
            check("d_tail", 64'(bus.is_tail_out), 64'(i == 11));
            check("d_tready", 64'(bus.axis_in_tready), (i == 3 || i == 7) ? 64'h1 : 64'h0);
        end
        nc();
        #1;
        check("d_done", 64'(bus.send_out), 64'h0);

        // Next beat late: locked channel waits, another valid channel is ignored.
        do_reset();
        bus.credit_in = 1'b1;
        set_ch(3, 32'h57565554, 1'b0, 2'd3, 4'hA, 1'b1);
        #1;
        check("g_grant", 64'(bus.axis_in_tready), 64'h8);
        for (int k = 0; k < 4; k++) begin
            nc();
            if (k == 0) bus.axis_in_tvalid = '0;
            #1;
            check("g_data", 64'(bus.data_out), 64'(8'h54 + k));
            check("g_tready", 64'(bus.axis_in_tready), (k == 3) ? 64'h8 : 64'h0);
        end
        nc();
        set_ch(0, 32'h11111111, 1'b1, 2'd0, 4'd0, 1'b1);
        #1;
        check("g_load_send", 64'(bus.send_out), 64'h0);
        check("g_locked", 64'(bus.axis_in_tready), 64'h0);
        nc();
        bus.axis_in_tvalid[0] = 1'b0;
        set_ch(3, 32'h5B5A5958, 1'b1, 2'd3, 4'hA, 1'b1);
        #1;
        check("g_load_xfer", 64'(bus.axis_in_tready), 64'h8);
        for (int k = 0; k < 4; k++) begin
            nc();
            if (k == 0) bus.axis_in_tvalid = '0;
            #1;
            check("g_data2", 64'(bus.data_out), 64'(8'h58 + k));
            check("g_dest", 64'(bus.dest_out), 64'h3A);
            check("g_tail", 64'(bus.is_tail_out), 64'(k == 3));
        end

        // Reset after flit 1 of a 2-beat packet.
        do_reset();
        bus.credit_in = 1'b1;
        set_ch(2, 32'h63626160, 1'b0, 2'd1, 4'd5, 1'b1);
        #1;
        check("e_grant", 64'(bus.axis_in_tready), 64'h4);
        nc();
        set_ch(2, 32'h67666564, 1'b1, 2'd1, 4'd5, 1'b1);
        #1;
        check("e_f0", 64'(bus.data_out), 64'h60);
        nc();
        #1;
        check("e_f1", 64'(bus.data_out), 64'h61);
        nc();
        rst_noc_sync = 1'b1;
        #1;
        check("e_rst_send", 64'(bus.send_out), 64'h0);
        check("e_rst_tready", 64'(bus.axis_in_tready), 64'h0);
        check("e_rst_tail", 64'(bus.is_tail_out), 64'h0);
        nc();
        rst_noc_sync = 1'b0;
        bus.credit_in = 1'b0;
        set_ch(0, 32'h73727170, 1'b1, 2'd0, 4'd1, 1'b1);
        #1;
        check("e_prio", 64'(bus.axis_in_tready), 64'h1);
        check("e_post_send", 64'(bus.send_out), 64'h0);
        check("e_post_tail", 64'(bus.is_tail_out), 64'h0);
        for (int k = 0; k < 4; k++) begin
            nc();
            if (k == 0) bus.axis_in_tvalid[0] = 1'b0;
            #1;
            check("e_send", 64'(bus.send_out), 64'h1);
            check("e_data", 64'(bus.data_out), 64'(8'h70 + k));
            check("e_dest", 64'(bus.dest_out), 64'h01);
            check("e_tail", 64'(bus.is_tail_out), 64'(k == 3));
        end
        nc();
        #1;
        check("e_next_grant", 64'(bus.axis_in_tready), 64'h4);
        nc();
        bus.axis_in_tvalid = '0;
        #1;
        check("e_credits_out", 64'(bus.send_out), 64'h0);

`ifdef AXIS_MUX_SERIALIZER_STATS_EN
        // Five single-beat packets on channel 3.
        do_reset();
        bus.credit_in = 1'b1;
        set_ch(3, 32'h0F0E0D0C, 1'b1, 2'd3, 4'd7, 1'b1);
        for (int i = 0; i < 24; i++) begin
            nc();
            if (i == 20) bus.axis_in_tvalid = '0;
        end
        nc();
        nc();
        #1;
        for (int c = 0; c < 4; c++) begin
            check("f_pkt_count", 64'(pkt_count[c]), (c == 3) ? 64'd5 : 64'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
